// File: rtl/uma_grant_decoder.sv
// Grant side of the UMA priority-encoder pair: registered one-hot grant with turnaround.
// Latency 1 edge from request to grant; optional forced release under UMA_GRANT_TIMEOUT_EN.
module uma_grant_decoder #(
  parameter int WIDTH       = 8,
  parameter int IDX_W       = 3,
  parameter int TURN_CYCLES = 1,
  parameter int TIMEOUT     = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             enc_enable_n,
  input  logic             req_valid,
  input  logic [IDX_W-1:0] req_index,
  input  logic [WIDTH-1:0] release_i,
  output logic [WIDTH-1:0] grant,
  output logic [IDX_W-1:0] grant_index,
  output logic             busy,
  output logic             timeout_err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_TURN  = 2'd2
  } state_t;

  generate
    if (TURN_CYCLES < 1 || TURN_CYCLES > 15 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_param
      $error("uma_grant_decoder: TURN_CYCLES must be 1..15 and TIMEOUT 1..255");
    end
  endgenerate

  state_t     state;
  logic [3:0] turn_cnt;
  logic       req_ok;
  logic       rel_hit;
  logic       to_hit;
  logic       rel_evt;

  // Non-power-of-two WIDTH can present an index with no master behind it.
  assign req_ok  = req_valid && (int'(req_index) < WIDTH);
  assign rel_hit = release_i[grant_index];
  assign rel_evt = rel_hit || to_hit;

`ifdef UMA_GRANT_TIMEOUT_EN
  logic [7:0] to_cnt;

  assign to_hit = (state == S_GRANT) && (to_cnt == 8'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      to_cnt      <= (state == S_GRANT) ? to_cnt + 8'd1 : 8'd0;
      // A genuine release on the same edge wins; only a forced release flags an error.
      timeout_err <= to_hit && !rel_hit;
    end
  end
`else
  assign to_hit      = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      grant        <= '0;
      grant_index  <= '0;
      busy         <= 1'b0;
      enc_enable_n <= 1'b0;
      turn_cnt     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_ok) begin
            grant        <= WIDTH'(1) << req_index;
            grant_index  <= req_index;
            busy         <= 1'b1;
            enc_enable_n <= 1'b1;
            state        <= S_GRANT;
          end
        end
        S_GRANT: begin
          if (rel_evt) begin
            grant    <= '0;
            turn_cnt <= 4'(TURN_CYCLES - 1);
            state    <= S_TURN;
          end
        end
        S_TURN: begin
          if (turn_cnt == 4'd0) begin
            busy         <= 1'b0;
            enc_enable_n <= 1'b0;
            state        <= S_IDLE;
          end else begin
            turn_cnt <= turn_cnt - 4'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uma_grant_decoder.sv
// Directed bench for uma_grant_decoder: vector table plus reset, back-to-back and timeout sequences.
module tb_uma_grant_decoder;

  localparam int NDUT = 2;

  logic       clk;
  logic       rst_n;
  logic       rv   [NDUT];
  logic [2:0] ri   [NDUT];
  logic [7:0] rel  [NDUT];
  logic       en_n [NDUT];
  logic [7:0] g    [NDUT];
  logic [2:0] gi   [NDUT];
  logic       bsy  [NDUT];
  logic       terr [NDUT];

  int n_chk;
  int n_fail;

  // Instance 0 uses TURN_CYCLES=1, instance 1 uses TURN_CYCLES=3.
  for (genvar d = 0; d < NDUT; d++) begin : g_dut
    uma_grant_decoder #(
      .WIDTH(8), .IDX_W(3), .TURN_CYCLES((d == 0) ? 1 : 3), .TIMEOUT(4)
    ) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .enc_enable_n(en_n[d]),
      .req_valid   (rv[d]),
      .req_index   (ri[d]),
      .release_i   (rel[d]),
      .grant       (g[d]),
      .grant_index (gi[d]),
      .busy        (bsy[d]),
      .timeout_err (terr[d])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rv;
    logic [2:0] ri;
    logic [7:0] rel;
    logic [7:0] g;
    logic [2:0] gi;
    logic       b;
    logic       en;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic v, logic [2:0] i, logic [7:0] r,
                              logic [7:0] eg, logic [2:0] egi, logic eb, logic een);
    vec_t t;
    t.rv = v; t.ri = i; t.rel = r; t.g = eg; t.gi = egi; t.b = eb; t.en = een;
    return t;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic back_to_back(input int d, input int turn);
    int zeros;
    @(negedge clk);
    rv[d] = 1'b1; ri[d] = 3'd0; rel[d] = '0;
    tick();
    chk($sformatf("b2b%0d first grant", d), g[d], 8'h01);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      rel[d] = 8'h01;
      tick();
      chk($sformatf("b2b%0d release drop", d), g[d], 8'h00);
      @(negedge clk);
      rel[d] = 8'h00;
      zeros = 1;
      for (int c = 0; c < 20 && g[d] == 8'h00; c++) begin
        tick();
        if (g[d] == 8'h00) zeros++;
      end
      chk($sformatf("b2b%0d regrant", d), g[d], 8'h01);
      chk($sformatf("b2b%0d gap cycles", d), zeros, turn + 1);
    end
    @(negedge clk);
    rv[d] = 1'b0; rel[d] = 8'h01;
    @(negedge clk);
    rel[d] = 8'h00;
    repeat (5) @(negedge clk);
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    for (int d = 0; d < NDUT; d++) begin
      rv[d] = 1'b0; ri[d] = 3'd0; rel[d] = 8'h00;
    end
    rst_n = 1'b0;
    #1;
    chk("reset grant", g[0], 0);
    chk("reset busy", bsy[0], 0);
    chk("reset enc_enable_n", en_n[0], 0);
    chk("reset timeout_err", terr[0], 0);
    chk("reset grant_index", gi[0], 0);
    @(negedge clk);
    rst_n = 1'b1;

    //        rv  ri    rel     grant  gi   busy en_n
    repeat (5) vq.push_back(mk(0, 0, 8'h00, 8'h00, 0, 0, 0));
    vq.push_back(mk(1, 5, 8'h00, 8'h20, 5, 1, 1));  // basic grant
    vq.push_back(mk(0, 0, 8'h00, 8'h20, 5, 1, 1));
    vq.push_back(mk(0, 0, 8'h20, 8'h00, 5, 1, 1));  // release -> TURN
    vq.push_back(mk(0, 0, 8'h00, 8'h00, 5, 0, 0));  // TURN done -> IDLE
    vq.push_back(mk(1, 2, 8'h00, 8'h04, 2, 1, 1));
    vq.push_back(mk(0, 0, 8'hFB, 8'h04, 2, 1, 1));  // foreign release ignored
    vq.push_back(mk(0, 0, 8'h00, 8'h04, 2, 1, 1));
    vq.push_back(mk(1, 6, 8'h04, 8'h00, 2, 1, 1));  // release wins over req
    vq.push_back(mk(1, 6, 8'h00, 8'h00, 2, 0, 0));  // req ignored in TURN
    vq.push_back(mk(1, 6, 8'h00, 8'h40, 6, 1, 1));
    vq.push_back(mk(0, 0, 8'h40, 8'h00, 6, 1, 1));
    vq.push_back(mk(0, 0, 8'h40, 8'h00, 6, 0, 0));  // level release in TURN
    vq.push_back(mk(1, 6, 8'h40, 8'h40, 6, 1, 1));  // release seen in IDLE ignored
    vq.push_back(mk(0, 0, 8'h40, 8'h00, 6, 1, 1));  // sampled in GRANT -> released
    vq.push_back(mk(0, 0, 8'h00, 8'h00, 6, 0, 0));

    foreach (vq[i]) begin
      @(negedge clk);
      rv[0] = vq[i].rv; ri[0] = vq[i].ri; rel[0] = vq[i].rel;
      tick();
      chk($sformatf("vec%0d grant", i), g[0], vq[i].g);
      chk($sformatf("vec%0d grant_index", i), gi[0], vq[i].gi);
      chk($sformatf("vec%0d busy", i), bsy[0], vq[i].b);
      chk($sformatf("vec%0d enc_enable_n", i), en_n[0], vq[i].en);
      chk($sformatf("vec%0d timeout_err", i), terr[0], 0);
    end

    // Asynchronous reset in the middle of a grant.
    @(negedge clk);
    rv[0] = 1'b1; ri[0] = 3'd7; rel[0] = 8'h00;
    tick();
    chk("arst pre grant", g[0], 8'h80);
    rv[0] = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst grant", g[0], 0);
    chk("arst busy", bsy[0], 0);
    chk("arst enc_enable_n", en_n[0], 0);
    @(negedge clk);
    rst_n = 1'b1;

    back_to_back(0, 1);
    back_to_back(1, 3);

    @(negedge clk);
    rv[0] = 1'b1; ri[0] = 3'd3; rel[0] = 8'h00;
    tick();
    chk("hold grant", g[0], 8'h08);
    @(negedge clk);
    rv[0] = 1'b0;
`ifdef UMA_GRANT_TIMEOUT_EN
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("timeout held %0d", c), g[0], 8'h08);
      chk($sformatf("timeout err quiet %0d", c), terr[0], 0);
    end
    tick();
    chk("timeout drop", g[0], 8'h00);
    chk("timeout err pulse", terr[0], 1);
    tick();
    chk("timeout err clear", terr[0], 0);
    chk("timeout busy", bsy[0], 0);
`else
    begin
      int bad_g;
      int bad_e;
      bad_g = 0;
      bad_e = 0;
      for (int c = 0; c < 300; c++) begin
        tick();
        if (g[0] != 8'h08) bad_g++;
        if (terr[0] != 1'b0) bad_e++;
      end
      chk("hold 300 grant errors", bad_g, 0);
      chk("hold 300 timeout_err errors", bad_e, 0);
    end
    @(negedge clk);
    rel[0] = 8'h08;
    tick();
    chk("hold release", g[0], 8'h00);
    rel[0] = 8'h00;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
